// File: rtl/wd_ctrl_pkg.sv
// wd_ctrl_pkg: shared types and constants for the watchdog recovery controller.
// Holds the FSM state enum, counter width and trip-count saturation helper.
package wd_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_TRIPPED,
      S_HOLDOFF,
      S_LOCKOUT
   } wd_ctrl_state_t;

   localparam int         WD_CTRL_CNT_W = 16;
   localparam logic [3:0] WD_TRIP_MAX   = 4'd15;

   function automatic logic [3:0] trip_inc(input logic [3:0] c);
      return (c == WD_TRIP_MAX) ? c : c + 4'd1;
   endfunction

endpackage

// File: rtl/hb_round_collector.sv
// hb_round_collector: accumulates masked heartbeat pulses into seen-bits and
// flags round completion. Ports: clk, rstn, en, clear, hb_req, src_mask, round_done.
module hb_round_collector
   import wd_ctrl_pkg::*;
#(
   parameter int N_SRC = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             clear,
   input  logic [N_SRC-1:0] hb_req,
   input  logic [N_SRC-1:0] src_mask,
   output logic             round_done
);

   logic [N_SRC-1:0] seen;
   logic [N_SRC-1:0] acc;

   assign acc = seen | (hb_req & src_mask);

   // An empty mask never completes a round.
   assign round_done = en && (src_mask != '0) &&
                       ((acc & src_mask) == src_mask);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         seen <= '0;
      end else if (clear || round_done) begin
         seen <= '0;
      end else if (en) begin
         seen <= acc;
      end
   end

endmodule

// File: rtl/wd_recovery_ctrl.sv
// wd_recovery_ctrl: watchdog supervisor. Issues heartbeats per check-in round,
// arms/disarms the watchdog, and on a trip mutes RF, pulses sys_reset_req for
// RST_CYCLES, holds off HOLDOFF_CYCLES, then re-arms or idles.
// Inputs: clk, rstn, arm, disarm, clear_fault, force_trip, hb_req, src_mask,
// wd_triggered, wd_warning. Outputs: wd_enable, wd_heartbeat, wd_force_reset,
// rf_mute, sys_reset_req, trip_count, locked_out, late_flag.
// Define WD_CTRL_LOCKOUT_EN to enable LOCKOUT after MAX_TRIPS consecutive trips.
module wd_recovery_ctrl
   import wd_ctrl_pkg::*;
#(
   parameter int N_SRC          = 2,
   parameter int RST_CYCLES     = 16,
   parameter int HOLDOFF_CYCLES = 1024,
   parameter int MAX_TRIPS      = 3
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             arm,
   input  logic             disarm,
   input  logic             clear_fault,
   input  logic             force_trip,
   input  logic [N_SRC-1:0] hb_req,
   input  logic [N_SRC-1:0] src_mask,
   input  logic             wd_triggered,
   input  logic             wd_warning,
   output logic             wd_enable,
   output logic             wd_heartbeat,
   output logic             wd_force_reset,
   output logic             rf_mute,
   output logic             sys_reset_req,
   output logic [3:0]       trip_count,
   output logic             locked_out,
   output logic             late_flag
);

`ifdef WD_CTRL_LOCKOUT_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   localparam logic [WD_CTRL_CNT_W-1:0] RST_LOAD =
      WD_CTRL_CNT_W'(RST_CYCLES - 1);
   localparam logic [WD_CTRL_CNT_W-1:0] HOLD_LOAD =
      WD_CTRL_CNT_W'(HOLDOFF_CYCLES - 1);

   wd_ctrl_state_t           state;
   logic [WD_CTRL_CNT_W-1:0] cnt;
   logic                     lock_q;
   logic                     round_done;
   logic                     armed;
   logic                     rc_clear;

   assign armed      = (state == S_ARMED);
   assign rc_clear   = !armed || wd_triggered || disarm;
   assign locked_out = lock_q & LOCK_EN;

   hb_round_collector #(
      .N_SRC(N_SRC)
   ) u_rc (
      .clk       (clk),
      .rstn      (rstn),
      .en        (armed),
      .clear     (rc_clear),
      .hb_req    (hb_req),
      .src_mask  (src_mask),
      .round_done(round_done)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state          <= S_IDLE;
         cnt            <= '0;
         trip_count     <= '0;
         wd_enable      <= 1'b0;
         wd_heartbeat   <= 1'b0;
         wd_force_reset <= 1'b0;
         rf_mute        <= 1'b0;
         sys_reset_req  <= 1'b0;
         lock_q         <= 1'b0;
         late_flag      <= 1'b0;
      end else begin
         wd_heartbeat   <= 1'b0;
         wd_force_reset <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (arm && !disarm) begin
                  state     <= S_ARMED;
                  wd_enable <= 1'b1;
               end
            end
            S_ARMED: begin
               wd_force_reset <= force_trip;
               // A trip outranks both round completion and disarm.
               if (wd_triggered) begin
                  state         <= S_TRIPPED;
                  cnt           <= RST_LOAD;
                  trip_count    <= trip_inc(trip_count);
                  wd_enable     <= 1'b0;
                  rf_mute       <= 1'b1;
                  sys_reset_req <= 1'b1;
                  if (wd_warning) late_flag <= 1'b1;
               end else begin
                  if (round_done) begin
                     wd_heartbeat <= 1'b1;
                     trip_count   <= '0;
                     late_flag    <= 1'b0;
                  end else if (wd_warning) begin
                     late_flag <= 1'b1;
                  end
                  if (disarm) begin
                     state     <= S_IDLE;
                     wd_enable <= 1'b0;
                  end
               end
            end
            S_TRIPPED: begin
               if (cnt == '0) begin
                  state         <= S_HOLDOFF;
                  cnt           <= HOLD_LOAD;
                  sys_reset_req <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_HOLDOFF: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (LOCK_EN &&
                            trip_count >= 4'(MAX_TRIPS)) begin
                  state  <= S_LOCKOUT;
                  lock_q <= 1'b1;
               end else begin
                  state     <= arm ? S_ARMED : S_IDLE;
                  wd_enable <= arm;
                  rf_mute   <= 1'b0;
               end
            end
            S_LOCKOUT: begin
               if (clear_fault) begin
                  state      <= S_IDLE;
                  trip_count <= '0;
                  rf_mute    <= 1'b0;
                  lock_q     <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wd_recovery_ctrl.sv
// tb_wd_recovery_ctrl: directed plus randomized checks of wd_recovery_ctrl
// against a phase-level reference model (mode + elapsed-time counter).
module tb_wd_recovery_ctrl;

   localparam int RST_C  = 16;
   localparam int HOLD_C = 1024;
   localparam int MAXT   = 3;

`ifdef WD_CTRL_LOCKOUT_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   localparam int M_IDLE = 0;
   localparam int M_ARM  = 1;
   localparam int M_RST  = 2;
   localparam int M_HOLD = 3;
   localparam int M_LOCK = 4;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       arm = 1'b0;
   logic       disarm = 1'b0;
   logic       clear_fault = 1'b0;
   logic       force_trip = 1'b0;
   logic       wd_triggered = 1'b0;
   logic       wd_warning = 1'b0;
   logic [1:0] hb_req = 2'b00;
   logic [1:0] src_mask = 2'b00;
   logic       wd_enable;
   logic       wd_heartbeat;
   logic       wd_force_reset;
   logic       rf_mute;
   logic       sys_reset_req;
   logic [3:0] trip_count;
   logic       locked_out;
   logic       late_flag;

   int n_cmp = 0;
   int n_err = 0;

   int     m_mode;
   int     m_el;
   int     m_tc;
   bit [1:0] m_seen;
   bit     m_late;
   bit     m_hb;
   bit     m_fr;

   always #5 clk = ~clk;

   wd_recovery_ctrl #(
      .N_SRC(2),
      .RST_CYCLES(RST_C),
      .HOLDOFF_CYCLES(HOLD_C),
      .MAX_TRIPS(MAXT)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .arm           (arm),
      .disarm        (disarm),
      .clear_fault   (clear_fault),
      .force_trip    (force_trip),
      .hb_req        (hb_req),
      .src_mask      (src_mask),
      .wd_triggered  (wd_triggered),
      .wd_warning    (wd_warning),
      .wd_enable     (wd_enable),
      .wd_heartbeat  (wd_heartbeat),
      .wd_force_reset(wd_force_reset),
      .rf_mute       (rf_mute),
      .sys_reset_req (sys_reset_req),
      .trip_count    (trip_count),
      .locked_out    (locked_out),
      .late_flag     (late_flag)
   );

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE;
      m_el   = 0;
      m_tc   = 0;
      m_seen = 2'b00;
      m_late = 1'b0;
      m_hb   = 1'b0;
      m_fr   = 1'b0;
   endtask

   task automatic model_edge();
      bit [1:0] acc;
      bit       done;
      m_hb = 1'b0;
      m_fr = 1'b0;
      case (m_mode)
         M_IDLE: begin
            m_seen = 2'b00;
            if (arm && !disarm) m_mode = M_ARM;
         end
         M_ARM: begin
            acc  = m_seen | (hb_req & src_mask);
            done = (src_mask != 2'b00) && ((acc & src_mask) == src_mask);
            m_fr = force_trip;
            if (wd_triggered) begin
               m_mode = M_RST;
               m_el   = 0;
               m_seen = 2'b00;
               if (m_tc < 15) m_tc++;
               if (wd_warning) m_late = 1'b1;
            end else begin
               if (done) begin
                  m_hb   = 1'b1;
                  m_seen = 2'b00;
                  m_tc   = 0;
                  m_late = 1'b0;
               end else begin
                  m_seen = acc;
                  if (wd_warning) m_late = 1'b1;
               end
               if (disarm) begin
                  m_mode = M_IDLE;
                  m_seen = 2'b00;
               end
            end
         end
         M_RST: begin
            m_el++;
            if (m_el == RST_C) begin
               m_mode = M_HOLD;
               m_el   = 0;
            end
         end
         M_HOLD: begin
            m_el++;
            if (m_el == HOLD_C) begin
               m_el = 0;
               if (LOCK && m_tc >= MAXT) m_mode = M_LOCK;
               else m_mode = arm ? M_ARM : M_IDLE;
            end
         end
         M_LOCK: begin
            if (clear_fault) begin
               m_mode = M_IDLE;
               m_tc   = 0;
            end
         end
         default: m_mode = M_IDLE;
      endcase
   endtask

   task automatic compare_all();
      chk("wd_enable", wd_enable, m_mode == M_ARM);
      chk("rf_mute", rf_mute,
          m_mode == M_RST || m_mode == M_HOLD || m_mode == M_LOCK);
      chk("sys_reset_req", sys_reset_req, m_mode == M_RST);
      chk("locked_out", locked_out, m_mode == M_LOCK);
      chk("wd_heartbeat", wd_heartbeat, m_hb);
      chk("wd_force_reset", wd_force_reset, m_fr);
      chk("trip_count", trip_count, 16'(m_tc));
      chk("late_flag", late_flag, m_late);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic wait_recovery();
      for (int i = 0; i < 3000 && (m_mode == M_RST || m_mode == M_HOLD); i++)
         step();
   endtask

   task automatic trip_once();
      wd_triggered = 1'b1;
      step();
      wd_triggered = 1'b0;
   endtask

   initial begin
      int rc;
      int mc;
      int tcb;
      model_reset();
      #3;
      chk("reset_outputs",
          {wd_enable, wd_heartbeat, wd_force_reset, rf_mute,
           sys_reset_req, locked_out, late_flag, trip_count}, 16'h0);
      #4 rstn = 1'b1;

      // Round of two sources, hb[1] three cycles after hb[0].
      arm      = 1'b1;
      src_mask = 2'b11;
      step();
      chk("arm_enable", wd_enable, 1'b1);
      hb_req = 2'b01;
      step();
      hb_req = 2'b00;
      chk("hb_after_src0", wd_heartbeat, 1'b0);
      step();
      step();
      hb_req = 2'b10;
      step();
      hb_req = 2'b00;
      chk("hb_after_src1", wd_heartbeat, 1'b1);
      step();
      chk("hb_single_pulse", wd_heartbeat, 1'b0);

      // Trip timing.
      force_trip = 1'b1;
      step();
      force_trip = 1'b0;
      chk("force_reset_pulse", wd_force_reset, 1'b1);
      trip_once();
      rc = 0;
      mc = 0;
      for (int i = 0; i < 3000 && rf_mute; i++) begin
         rc += int'(sys_reset_req);
         mc += int'(rf_mute);
         step();
      end
      chk("rst_pulse_len", 16'(rc), 16'(RST_C));
      chk("mute_len", 16'(mc), 16'(RST_C + HOLD_C));
      chk("rearm_enable", wd_enable, 1'b1);
      chk("trip_count_1", trip_count, 4'd1);

      // Two further trips without a complete round.
      for (int k = 0; k < 2; k++) begin
         trip_once();
         wait_recovery();
      end
`ifdef WD_CTRL_LOCKOUT_EN
      chk("lockout_entered", locked_out, 1'b1);
      chk("lockout_tc", trip_count, 4'd3);
      disarm = 1'b1;
      step();
      disarm = 1'b0;
      chk("lockout_disarm_ignored", locked_out, 1'b1);
      clear_fault = 1'b1;
      step();
      clear_fault = 1'b0;
      chk("clear_to_idle", wd_enable, 1'b0);
      chk("clear_tc", trip_count, 4'd0);
      step();
`else
      chk("rearm_after_3", wd_enable, 1'b1);
      chk("trip_count_3", trip_count, 4'd3);
`endif

      // Round completion coincident with a trip.
      tcb    = m_tc;
      hb_req = 2'b11;
      trip_once();
      hb_req = 2'b00;
      chk("same_cycle_no_hb", wd_heartbeat, 1'b0);
      chk("same_cycle_trip", sys_reset_req, 1'b1);
      chk("same_cycle_tc", trip_count, 16'(tcb + 1));
      wait_recovery();

      // Asynchronous reset in the fifth TRIPPED cycle.
      trip_once();
      repeat (4) step();
      rstn = 1'b0;
      #1;
      model_reset();
      chk("async_rst_outputs",
          {wd_enable, wd_heartbeat, wd_force_reset, rf_mute,
           sys_reset_req, locked_out, late_flag, trip_count}, 16'h0);
      arm = 1'b0;
      #2 rstn = 1'b1;
      step();
      chk("post_rst_idle", wd_enable, 1'b0);
      arm = 1'b1;
      step();

      // Single-source mask, then empty mask.
      src_mask = 2'b01;
      for (int k = 0; k < 3; k++) begin
         hb_req = 2'b01;
         step();
         hb_req = 2'b00;
         chk("mask01_hb", wd_heartbeat, 1'b1);
         step();
      end
      src_mask = 2'b00;
      for (int k = 0; k < 4; k++) begin
         hb_req = 2'b11;
         step();
         chk("mask0_no_hb", wd_heartbeat, 1'b0);
      end
      hb_req = 2'b00;
      trip_once();
      chk("mask0_trip", sys_reset_req, 1'b1);
      wait_recovery();

      // Randomized operation.
      src_mask = 2'b11;
      for (int i = 0; i < 25000; i++) begin
         arm          = ($urandom % 10) != 0;
         disarm       = ($urandom % 300) == 0;
         clear_fault  = ($urandom % 40) == 0;
         force_trip   = ($urandom % 20) == 0;
         wd_triggered = ($urandom % 250) == 0;
         wd_warning   = ($urandom % 30) == 0;
         hb_req[0]    = ($urandom % 4) == 0;
         hb_req[1]    = ($urandom % 4) == 0;
         if (($urandom % 200) == 0) src_mask = 2'($urandom % 4);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
